operand_loader: RTL and testbench
=================================

# operand_loader

Serial-in operand loader that sits directly upstream of the two-operand AND-OR reduction stage. It assembles two `W`-bit operands from a 1-bit serial stream, checking an even-parity bit after each operand. It presents `x_out`/`y_out` to the reduction stage with a valid/ready handshake. A parity failure discards the frame and pulses an error flag.

## Interface
- `W`, default 8: operand width in bits; must be ≥ 2.
- `clk`  in  1  sole clock; all logic on the rising edge.
- `rst_n`  in  1  reset, synchronous, active-low.
- `start`  in  1  begins a frame; honoured only in IDLE.
- `bit_in`  in  1  serial data bit, LSB first.
- `bit_valid`  in  1  `bit_in` is sampled on this cycle.
- `x_out`  out  W  first operand, registered.
- `y_out`  out  W  second operand, registered.
- `out_valid`  out  1  `x_out`/`y_out` hold a committed frame.
- `out_ready`  in  1  downstream accepts the frame.
- `busy`  out  1  high in every state except IDLE.
- `parity_err`  out  1  one-cycle pulse when a frame is rejected.

## Operation
- Frame format: `W` X bits, then X parity bit, then `W` Y bits, then Y parity bit.
  - Only cycles with `bit_valid=1` advance the frame; gaps of any length are allowed.
- Parity is even: the parity bit must equal the XOR of the preceding `W` data bits.
- States:
  - IDLE: `start` → LOAD_X, bit counter cleared.
  - LOAD_X: shift in `W` valid bits, then → PAR_X.
  - PAR_X: on a valid bit, match → LOAD_Y; mismatch → IDLE and pulse `parity_err`.
  - LOAD_Y: shift in `W` valid bits, then → PAR_Y.
  - PAR_Y: on a valid bit, match → HOLD and commit both operands to `x_out`/`y_out`; mismatch → IDLE and pulse `parity_err`.
  - HOLD: `out_valid=1`; `out_ready` → IDLE.
- Shift registers are internal. `x_out`/`y_out` change only at commit and hold their value through IDLE until the next successful commit.
- `start` is ignored outside IDLE. `bit_valid` is ignored in IDLE and HOLD.
- Bit counter width is `$clog2(W+1)`. It clears on every entry to LOAD_X and LOAD_Y.

## Timing
- Reset values:
  - Outputs: `x_out=0`, `y_out=0`, `out_valid=0`, `busy=0`, `parity_err=0`.
  - Internals: state IDLE, counter 0.
- Reset asserted mid-frame aborts the frame. No `out_valid` and no `parity_err` are produced.
- The `start` cycle itself samples no data, even if `bit_valid=1` on that cycle.
- `out_valid` rises on the cycle after the accepted Y parity bit. With `bit_valid` held high, this is 2W+3 cycles after `start`.
- `parity_err` is high for exactly the one cycle after the failing parity bit. The state is IDLE on that same cycle.
- `busy` rises on the cycle after `start` and falls on the cycle after the HOLD handshake or the parity failure.
- `out_valid && out_ready` in HOLD: `out_valid=0` on the next cycle.
  - `start` asserted on that next cycle (IDLE) is honoured, giving a back-to-back frame.
- `out_ready` while `out_valid=0` has no effect.

## Structure
- Shared include `operand_loader_defs.vh` holds:
  - the state encodings (IDLE, LOAD_X, PAR_X, LOAD_Y, PAR_Y, HOLD, 3-bit);
  - the default width constant.
- One sub-module, `serial_shift_in`:
  - parameter `W`; ports `clk`, `rst_n`, `clr`, `en`, `d`;
  - outputs the `W`-bit LSB-first shift value and its running XOR.
  - Instantiate it twice, once for X and once for Y.
- The FSM, counter, commit registers and handshake live in the top module.

## Test plan
- `W=8`, `bit_valid` held high. Send X=0xA5 with parity 0, then Y=0x3C with parity 0.
  - Required: `out_valid` rises 19 cycles after `start`, with `x_out=0xA5` and `y_out=0x3C`.
  - Hold `out_ready=0` for 5 cycles: `out_valid` and the data stay stable. Then `out_ready=1`: the state returns to IDLE.
- X=0x07 sent with parity 0 (wrong).
  - Required: `parity_err` pulses once, `busy` falls, and the Y bits that follow are ignored.
  - `x_out`/`y_out` keep their prior values (0xA5/0x3C).
- Frame X=0x01 with parity 1, Y=0xFF with parity 0, with `bit_valid` dropped on every other cycle.
  - Required: identical result to the gap-free case, committing 0x01/0xFF.
- `rst_n` driven low for 1 cycle after 5 Y bits.
  - Required: all outputs 0 on the next cycle, no `out_valid`, and the next full frame loads correctly.
- Send `start` with `bit_valid=1` and `bit_in=1` on the same cycle.
  - Required: that bit is not sampled.
- Send `start` pulses during LOAD_Y and HOLD.
  - Required: no effect.
- Assert `start` on the cycle right after the HOLD handshake.
  - Required: the second frame is accepted with no dead cycle.

Source files
------------

// File: rtl/operand_loader_pkg.sv
// Shared definitions for operand_loader: FSM state encodings and default operand width.
package operand_loader_pkg;

  localparam int unsigned DEFAULT_W = 8;

  localparam logic [2:0] ST_IDLE   = 3'd0;
  localparam logic [2:0] ST_LOAD_X = 3'd1;
  localparam logic [2:0] ST_PAR_X  = 3'd2;
  localparam logic [2:0] ST_LOAD_Y = 3'd3;
  localparam logic [2:0] ST_PAR_Y  = 3'd4;
  localparam logic [2:0] ST_HOLD   = 3'd5;

endpackage

// File: rtl/serial_shift_in.sv
// LSB-first serial-to-parallel shift register with running XOR of the shifted bits.
module serial_shift_in #(
  parameter int unsigned W = 8
) (
  input  logic         clk,
  input  logic         rst_n,
  input  logic         clr,
  input  logic         en,
  input  logic         d,
  output logic [W-1:0] o_q,
  output logic         o_par
);

  // Shift new bits in at the MSB so the first bit received ends up at bit 0.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      o_q   <= '0;
      o_par <= 1'b0;
    end else if (clr) begin
      o_q   <= '0;
      o_par <= 1'b0;
    end else if (en) begin
      o_q   <= {d, o_q[W-1:1]};
      o_par <= o_par ^ d;
    end
  end

endmodule

// File: rtl/operand_loader.sv
// Serial operand loader: assembles X and Y from a parity-checked bit stream and
// presents them with a valid/ready handshake.
module operand_loader
  import operand_loader_pkg::*;
#(
  parameter int unsigned W = DEFAULT_W
) (
  input  logic         clk,
  input  logic         rst_n,
  input  logic         start,
  input  logic         bit_in,
  input  logic         bit_valid,
  output logic [W-1:0] x_out,
  output logic [W-1:0] y_out,
  output logic         out_valid,
  input  logic         out_ready,
  output logic         busy,
  output logic         parity_err
);

  localparam int unsigned CW = $clog2(W + 1);

  logic [2:0]    r_state;
  logic [2:0]    w_state_nxt;
  logic [CW-1:0] r_cnt;
  logic [CW-1:0] w_cnt_nxt;

  logic          w_x_clr;
  logic          w_x_en;
  logic          w_y_clr;
  logic          w_y_en;
  logic          w_commit;
  logic          w_perr;
  logic          w_last;

  logic [W-1:0]  w_x_q;
  logic [W-1:0]  w_y_q;
  logic          w_x_par;
  logic          w_y_par;

  serial_shift_in #(.W(W)) u_shift_x (
    .clk   (clk),
    .rst_n (rst_n),
    .clr   (w_x_clr),
    .en    (w_x_en),
    .d     (bit_in),
    .o_q   (w_x_q),
    .o_par (w_x_par)
  );

  serial_shift_in #(.W(W)) u_shift_y (
    .clk   (clk),
    .rst_n (rst_n),
    .clr   (w_y_clr),
    .en    (w_y_en),
    .d     (bit_in),
    .o_q   (w_y_q),
    .o_par (w_y_par)
  );

  assign w_last = (r_cnt == CW'(W - 1));

  // Next-state, counter and datapath-control decode.
  always_comb begin
    w_state_nxt = r_state;
    w_cnt_nxt   = r_cnt;
    w_x_clr     = 1'b0;
    w_x_en      = 1'b0;
    w_y_clr     = 1'b0;
    w_y_en      = 1'b0;
    w_commit    = 1'b0;
    w_perr      = 1'b0;

    case (r_state)
      ST_IDLE: begin
        if (start) begin
          w_state_nxt = ST_LOAD_X;
          w_cnt_nxt   = '0;
          w_x_clr     = 1'b1;
        end
      end
      ST_LOAD_X: begin
        if (bit_valid) begin
          w_x_en = 1'b1;
          if (w_last) begin
            w_state_nxt = ST_PAR_X;
            w_cnt_nxt   = '0;
          end else begin
            w_cnt_nxt = r_cnt + CW'(1);
          end
        end
      end
      ST_PAR_X: begin
        if (bit_valid) begin
          if (bit_in == w_x_par) begin
            w_state_nxt = ST_LOAD_Y;
            w_cnt_nxt   = '0;
            w_y_clr     = 1'b1;
          end else begin
            w_state_nxt = ST_IDLE;
            w_perr      = 1'b1;
          end
        end
      end
      ST_LOAD_Y: begin
        if (bit_valid) begin
          w_y_en = 1'b1;
          if (w_last) begin
            w_state_nxt = ST_PAR_Y;
            w_cnt_nxt   = '0;
          end else begin
            w_cnt_nxt = r_cnt + CW'(1);
          end
        end
      end
      ST_PAR_Y: begin
        if (bit_valid) begin
          if (bit_in == w_y_par) begin
            w_state_nxt = ST_HOLD;
            w_commit    = 1'b1;
          end else begin
            w_state_nxt = ST_IDLE;
            w_perr      = 1'b1;
          end
        end
      end
      ST_HOLD: begin
        if (out_ready) begin
          w_state_nxt = ST_IDLE;
        end
      end
      default: begin
        w_state_nxt = ST_IDLE;
        w_cnt_nxt   = '0;
      end
    endcase
  end

  // State, counter and registered outputs; status flags follow the next state.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      r_state    <= ST_IDLE;
      r_cnt      <= '0;
      x_out      <= '0;
      y_out      <= '0;
      out_valid  <= 1'b0;
      busy       <= 1'b0;
      parity_err <= 1'b0;
    end else begin
      r_state    <= w_state_nxt;
      r_cnt      <= w_cnt_nxt;
      out_valid  <= (w_state_nxt == ST_HOLD);
      busy       <= (w_state_nxt != ST_IDLE);
      parity_err <= w_perr;
      if (w_commit) begin
        x_out <= w_x_q;
        y_out <= w_y_q;
      end
    end
  end

endmodule

// File: tb/tb_operand_loader.sv
// Directed bench for operand_loader with W=8: frame table plus corner-case sequences.
module tb_operand_loader;

  localparam int unsigned W = 8;

  logic         clk;
  logic         rst_n;
  logic         start;
  logic         bit_in;
  logic         bit_valid;
  logic [W-1:0] x_out;
  logic [W-1:0] y_out;
  logic         out_valid;
  logic         out_ready;
  logic         busy;
  logic         parity_err;

  int checks;
  int errors;

  operand_loader #(.W(W)) dut (
    .clk        (clk),
    .rst_n      (rst_n),
    .start      (start),
    .bit_in     (bit_in),
    .bit_valid  (bit_valid),
    .x_out      (x_out),
    .y_out      (y_out),
    .out_valid  (out_valid),
    .out_ready  (out_ready),
    .busy       (busy),
    .parity_err (parity_err)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  typedef struct {
    logic [7:0] x;
    logic       xp;
    logic [7:0] y;
    logic       yp;
    bit         gap;
    bit         xerr;
    bit         yerr;
    logic [7:0] ox;
    logic [7:0] oy;
    int         stall;
  } vec_t;

  vec_t vecs[6];

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
    end
  endtask

  // One serial bit, optionally preceded by an idle (bit_valid=0) cycle.
  task automatic send_bit(input logic b, input bit gap, inout int n);
    if (gap) begin
      bit_valid = 1'b0;
      tick();
      n++;
    end
    bit_valid = 1'b1;
    bit_in    = b;
    tick();
    n++;
    bit_valid = 1'b0;
    bit_in    = 1'b0;
  endtask

  task automatic run_frame(input logic [7:0] x, input logic xp, input logic [7:0] y,
                           input logic yp, input bit gap, input bit start_bv,
                           input bit start_in_y, input bit xerr, input bit yerr,
                           input logic [7:0] ox, input logic [7:0] oy);
    int n;
    bit spurious;
    n = 0;
    spurious = 1'b0;
    start     = 1'b1;
    bit_valid = start_bv;
    bit_in    = start_bv;
    tick();
    start     = 1'b0;
    bit_valid = 1'b0;
    bit_in    = 1'b0;
    chk("busy_rise", 32'(busy), 32'd1);
    for (int i = 0; i < 8; i++) send_bit(x[i], gap, n);
    send_bit(xp, gap, n);
    if (xerr) begin
      chk("xpar_err_pulse", 32'(parity_err), 32'd1);
      chk("xpar_busy_low", 32'(busy), 32'd0);
      out_ready = 1'b1;
      for (int i = 0; i < 8; i++) begin
        send_bit(y[i], gap, n);
        if (parity_err || out_valid || busy) spurious = 1'b1;
      end
      send_bit(yp, gap, n);
      if (parity_err || out_valid || busy) spurious = 1'b1;
      out_ready = 1'b0;
      chk("xerr_y_ignored", 32'(spurious), 32'd0);
      chk("xerr_x_kept", 32'(x_out), 32'(ox));
      chk("xerr_y_kept", 32'(y_out), 32'(oy));
      return;
    end
    start = start_in_y;
    for (int i = 0; i < 8; i++) send_bit(y[i], gap, n);
    start = 1'b0;
    send_bit(yp, gap, n);
    if (yerr) begin
      chk("ypar_err_pulse", 32'(parity_err), 32'd1);
      chk("ypar_busy_low", 32'(busy), 32'd0);
      chk("ypar_no_valid", 32'(out_valid), 32'd0);
      chk("yerr_xy_kept", 32'({x_out, y_out}), 32'({ox, oy}));
      tick();
      chk("ypar_err_one_cycle", 32'(parity_err), 32'd0);
      return;
    end
    chk("commit_valid", 32'(out_valid), 32'd1);
    chk("commit_x", 32'(x_out), 32'(ox));
    chk("commit_y", 32'(y_out), 32'(oy));
    chk("commit_latency", 32'(n + 1), gap ? 32'd37 : 32'd19);
  endtask

  // Stall the handshake, poking start meanwhile, then accept.
  task automatic handshake(input int stall, input logic [7:0] ox, input logic [7:0] oy);
    for (int k = 0; k < stall; k++) begin
      out_ready = 1'b0;
      start     = (k == 2);
      bit_valid = 1'b1;
      bit_in    = 1'b1;
      tick();
      chk("hold_stable", 32'({out_valid, busy, x_out, y_out}), 32'({2'b11, ox, oy}));
    end
    start     = 1'b0;
    bit_valid = 1'b0;
    bit_in    = 1'b0;
    out_ready = 1'b1;
    tick();
    out_ready = 1'b0;
    chk("hs_valid_low", 32'(out_valid), 32'd0);
    chk("hs_busy_low", 32'(busy), 32'd0);
  endtask

  initial begin
    bit spurious;
    checks    = 0;
    errors    = 0;
    rst_n     = 1'b0;
    start     = 1'b0;
    bit_in    = 1'b0;
    bit_valid = 1'b0;
    out_ready = 1'b0;

    vecs[0] = '{x:8'hA5, xp:1'b0, y:8'h3C, yp:1'b0, gap:1'b0, xerr:1'b0, yerr:1'b0, ox:8'hA5, oy:8'h3C, stall:5};
    vecs[1] = '{x:8'h07, xp:1'b0, y:8'h55, yp:1'b0, gap:1'b0, xerr:1'b1, yerr:1'b0, ox:8'hA5, oy:8'h3C, stall:0};
    vecs[2] = '{x:8'h01, xp:1'b1, y:8'hFF, yp:1'b0, gap:1'b1, xerr:1'b0, yerr:1'b0, ox:8'h01, oy:8'hFF, stall:0};
    vecs[3] = '{x:8'h5A, xp:1'b0, y:8'h81, yp:1'b1, gap:1'b0, xerr:1'b0, yerr:1'b1, ox:8'h01, oy:8'hFF, stall:0};
    vecs[4] = '{x:8'hFF, xp:1'b0, y:8'h00, yp:1'b0, gap:1'b1, xerr:1'b0, yerr:1'b0, ox:8'hFF, oy:8'h00, stall:1};
    vecs[5] = '{x:8'hC3, xp:1'b0, y:8'h7E, yp:1'b0, gap:1'b0, xerr:1'b0, yerr:1'b0, ox:8'hC3, oy:8'h7E, stall:0};

    tick();
    tick();
    chk("rst_outputs", 32'({x_out, y_out, out_valid, busy, parity_err}), 32'd0);
    rst_n = 1'b1;
    out_ready = 1'b1;
    tick();
    out_ready = 1'b0;
    chk("idle_ready_noeffect", 32'({out_valid, busy}), 32'd0);

    // Table frames; a committed frame's handshake is followed directly by the next start.
    foreach (vecs[i]) begin
      run_frame(vecs[i].x, vecs[i].xp, vecs[i].y, vecs[i].yp, vecs[i].gap, 1'b0, 1'b0,
                vecs[i].xerr, vecs[i].yerr, vecs[i].ox, vecs[i].oy);
      if (!vecs[i].xerr && !vecs[i].yerr) handshake(vecs[i].stall, vecs[i].ox, vecs[i].oy);
    end

    // start with bit_valid=1 samples nothing; start during LOAD_Y and HOLD ignored.
    run_frame(8'h02, 1'b1, 8'h04, 1'b1, 1'b0, 1'b1, 1'b1, 1'b0, 1'b0, 8'h02, 8'h04);
    handshake(4, 8'h02, 8'h04);

    // Reset mid-frame after 5 Y bits.
    begin
      int n;
      n = 0;
      start = 1'b1;
      tick();
      start = 1'b0;
      for (int i = 0; i < 8; i++) send_bit(((8'h11 >> i) & 8'h01) != 8'h00, 1'b0, n);
      send_bit(1'b0, 1'b0, n);
      for (int i = 0; i < 5; i++) send_bit(1'b1, 1'b0, n);
      chk("pre_rst_busy", 32'(busy), 32'd1);
      rst_n = 1'b0;
      tick();
      rst_n = 1'b1;
      chk("mid_rst_outputs", 32'({x_out, y_out, out_valid, busy, parity_err}), 32'd0);
      spurious = 1'b0;
      for (int i = 0; i < 4; i++) begin
        send_bit(1'b1, 1'b0, n);
        if (parity_err || out_valid || busy) spurious = 1'b1;
      end
      chk("post_rst_quiet", 32'(spurious), 32'd0);
    end
    run_frame(8'h3C, 1'b0, 8'hA5, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 8'h3C, 8'hA5);
    handshake(0, 8'h3C, 8'hA5);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
